mem_wb_stage: RTL

MEM stage plus M/WB pipeline register for the 5-stage MIPS core. It consumes the EX/M register outputs and runs a request/acknowledge transaction with a variable-latency data memory. It performs halfword lane selection and sign extension for Lh/Sh. It stalls the upstream pipe until the access completes, then registers write-back data, destination and RegWrite for the WB stage.

---
 rtl/mem_wb_stage.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
`timescale 1ns/1ps
// mem_wb_stage: MEM stage plus M/WB pipeline register.
//
// It runs a request/acknowledge access to a variable-latency data memory.
// While the access is in flight it stalls the upstream pipe, and when it
// completes it loads the write-back register. All state changes on the
// falling clock edge, like the other pipeline registers.
//
// Ports:
//   clk, rst            clock (falling-edge active) and async active-low reset
//   M_*                 EX/M register outputs (controls, ALU result, store data,
//                       PC+8, destination)
//   dm_req/we/addr/be/  data-memory request, held until dm_ack or timeout
//   wdata
//   dm_ack, dm_rdata    memory completion and read data
//   mem_stall           freeze IF/ID/EX/EX_M while an access is pending
//   misalign_err        one-cycle pulse: misaligned access dropped
//   bus_err             one-cycle pulse: access aborted on timeout
//   WB_*                registered write-back enable, destination and value
module mem_wb_stage #(
    parameter int unsigned data_size = 32,
    parameter int unsigned pc_size   = 18,
    parameter int unsigned addr_size = 16,
    parameter int unsigned timeout   = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   M_MemtoReg,
    input  logic                   M_RegWrite,
    input  logic                   M_MemRead,
    input  logic                   M_MemWrite,
    input  logic                   M_Jal,
    input  logic                   M_Lh,
    input  logic                   M_Sh,
    input  logic [data_size-1:0]   M_ALU_result,
    input  logic [data_size-1:0]   M_Rt_data,
    input  logic [pc_size-1:0]     M_PCplus8,
    input  logic [4:0]             M_WR_out,
    output logic                   dm_req,
    output logic                   dm_we,
    output logic [addr_size-3:0]   dm_addr,
    output logic [3:0]             dm_be,
    output logic [data_size-1:0]   dm_wdata,
    input  logic                   dm_ack,
    input  logic [data_size-1:0]   dm_rdata,
    output logic                   mem_stall,
    output logic                   misalign_err,
    output logic                   bus_err,
    output logic                   WB_RegWrite,
    output logic [4:0]             WB_WR_out,
    output logic [data_size-1:0]   WB_write_data
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 dm_req_q, dm_req_d;
    logic                 dm_we_q, dm_we_d;
    logic [addr_size-3:0] dm_addr_q, dm_addr_d;
    logic [3:0]           dm_be_q, dm_be_d;
    logic [data_size-1:0] dm_wdata_q, dm_wdata_d;
    logic                 misalign_q, misalign_d;
    logic                 bus_err_q, bus_err_d;
    logic                 wb_rw_q, wb_rw_d;
    logic [4:0]           wb_wr_q, wb_wr_d;
    logic [data_size-1:0] wb_data_q, wb_data_d;

    // Instruction context held for the write-back at the end of an access.
    logic                 lh_q, lh_d;
    logic                 a1_q, a1_d;
    logic                 sel_load_q, sel_load_d;
    logic [data_size-1:0] alt_q, alt_d;
    logic                 rw_q, rw_d;
    logic [4:0]           wr_q, wr_d;
    logic                 abort_q, abort_d;
    logic [data_size-1:0] rdata_q, rdata_d;

    logic                 memop, half_op, aligned, sel_load_now;
    logic [data_size-1:0] alt_now, load_data;
    logic [15:0]          half_word;

    always_comb begin
        memop        = M_MemRead | M_MemWrite;
        half_op      = (M_MemRead & M_Lh) | (M_MemWrite & M_Sh);
        aligned      = half_op ? ~M_ALU_result[0] : (M_ALU_result[1:0] == 2'b00);
        // Jal has priority over MemtoReg; the non-load candidate is chosen here.
        alt_now      = M_Jal ? {{(data_size-pc_size){1'b0}}, M_PCplus8} : M_ALU_result;
        sel_load_now = ~M_Jal & M_MemtoReg;
        half_word    = a1_q ? rdata_q[31:16] : rdata_q[15:0];
        load_data    = lh_q ? {{(data_size-16){half_word[15]}}, half_word} : rdata_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_be_d    = dm_be_q;
        dm_wdata_d = dm_wdata_q;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
        wb_rw_d    = wb_rw_q;
        wb_wr_d    = wb_wr_q;
        wb_data_d  = wb_data_q;
        lh_d       = lh_q;
        a1_d       = a1_q;
        sel_load_d = sel_load_q;
        alt_d      = alt_q;
        rw_d       = rw_q;
        wr_d       = wr_q;
        abort_d    = abort_q;
        rdata_d    = rdata_q;
        mem_stall  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (memop && aligned) begin
                    mem_stall  = 1'b1;
                    dm_req_d   = 1'b1;
                    dm_we_d    = M_MemWrite;
                    dm_addr_d  = M_ALU_result[addr_size-1:2];
                    if (!M_MemWrite) begin
                        dm_be_d    = 4'b0000;
                        dm_wdata_d = '0;
                    end else if (M_Sh) begin
                        dm_be_d    = M_ALU_result[1] ? 4'b1100 : 4'b0011;
                        dm_wdata_d = {M_Rt_data[15:0], M_Rt_data[15:0]};
                    end else begin
                        dm_be_d    = 4'b1111;
                        dm_wdata_d = M_Rt_data;
                    end
                    cnt_d      = 4'd0;
                    abort_d    = 1'b0;
                    lh_d       = M_Lh;
                    a1_d       = M_ALU_result[1];
                    sel_load_d = sel_load_now;
                    alt_d      = alt_now;
                    rw_d       = M_RegWrite;
                    wr_d       = M_WR_out;
                    wb_rw_d    = 1'b0;  // bubble while the access runs
                    state_d    = StBusy;
                end else begin
                    // A misaligned memop is dropped: no request, no write-back.
                    wb_rw_d    = M_RegWrite & ~memop;
                    wb_wr_d    = M_WR_out;
                    wb_data_d  = sel_load_now ? load_data : alt_now;
                    misalign_d = memop;
                end
            end
            StBusy: begin
                mem_stall = 1'b1;
                wb_rw_d   = 1'b0;
                if (dm_ack) begin
                    rdata_d  = dm_rdata;
                    dm_req_d = 1'b0;
                    state_d  = StDone;
                end else if (cnt_q == 4'(timeout - 1)) begin
                    dm_req_d  = 1'b0;
                    bus_err_d = 1'b1;
                    abort_d   = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                // Upstream advances on this edge; a new memop is examined in StIdle.
                wb_rw_d   = rw_q & ~abort_q;
                wb_wr_d   = wr_q;
                wb_data_d = sel_load_q ? load_data : alt_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_be_q    <= 4'b0000;
            dm_wdata_q <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_wr_q    <= 5'd0;
            wb_data_q  <= '0;
            lh_q       <= 1'b0;
            a1_q       <= 1'b0;
            sel_load_q <= 1'b0;
            alt_q      <= '0;
            rw_q       <= 1'b0;
            wr_q       <= 5'd0;
            abort_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_be_q    <= dm_be_d;
            dm_wdata_q <= dm_wdata_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
            wb_rw_q    <= wb_rw_d;
            wb_wr_q    <= wb_wr_d;
            wb_data_q  <= wb_data_d;
            lh_q       <= lh_d;
            a1_q       <= a1_d;
            sel_load_q <= sel_load_d;
            alt_q      <= alt_d;
            rw_q       <= rw_d;
            wr_q       <= wr_d;
            abort_q    <= abort_d;
            rdata_q    <= rdata_d;
        end
    end

    assign dm_req        = dm_req_q;
    assign dm_we         = dm_we_q;
    assign dm_addr       = dm_addr_q;
    assign dm_be         = dm_be_q;
    assign dm_wdata      = dm_wdata_q;
    assign misalign_err  = misalign_q;
    assign bus_err       = bus_err_q;
    assign WB_RegWrite   = wb_rw_q;
    assign WB_WR_out     = wb_wr_q;
    assign WB_write_data = wb_data_q;

endmodule
